// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the 5-stage pipeline. Captures the decoded
//   control bits, register operands, immediate, PC+1 and register fields of
//   the instruction in ID once per cycle, with exactly one cycle of latency.
//   It also detects load-use hazards: stall_o freezes PC and IF/ID while a
//   bubble is inserted into EX. A taken branch/jump (flush_i) kills the ID
//   instruction, and hold_i freezes the whole stage. A saturating counter
//   records how many bubbles have been injected.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   hold_i                           global freeze; ID/EX contents held
//   flush_i                          kill the instruction currently in ID
//   id_valid_i                       ID holds a real instruction
//   id_aluop_i/regdst_i/memtoreg_i   control unit fields (3/2/2 bits)
//   id_ctrl_i                        {alusrc,regwrite,memread,memwrite,
//                                     branch,jump,pcsrc}
//   id_rs_i/id_rt_i/id_rd_i          register fields of the ID instruction
//   id_uses_rs_i/id_uses_rt_i        the ID instruction reads rs / rt
//   id_a_i/id_b_i/id_imm_i/id_pc_i   operands, immediate, PC+1
//   stall_o                          freezes PC and IF/ID (combinational)
//   ex_*_o                           registered copy of the ID inputs
//   bubble_cnt_o                     saturating count of injected bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [2:0]        id_aluop_i,
    input  logic [1:0]        id_regdst_i,
    input  logic [1:0]        id_memtoreg_i,
    input  logic [6:0]        id_ctrl_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [DATA_W-1:0] id_a_i,
    input  logic [DATA_W-1:0] id_b_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [2:0]        ex_aluop_o,
    output logic [1:0]        ex_regdst_o,
    output logic [1:0]        ex_memtoreg_o,
    output logic [6:0]        ex_ctrl_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [DATA_W-1:0] ex_a_o,
    output logic [DATA_W-1:0] ex_b_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // Position of memread inside the packed control vector.
    localparam int CTRL_MEMREAD = 4;

    logic              valid_q,    valid_d;
    logic [2:0]        aluop_q,    aluop_d;
    logic [1:0]        regdst_q,   regdst_d;
    logic [1:0]        memtoreg_q, memtoreg_d;
    logic [6:0]        ctrl_q,     ctrl_d;
    logic [REG_AW-1:0] rs_q,       rs_d;
    logic [REG_AW-1:0] rt_q,       rt_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [DATA_W-1:0] a_q,        a_d;
    logic [DATA_W-1:0] b_q,        b_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic hazard;
    logic bubble;

    // Load in EX writing a non-zero rt that the ID instruction reads: the
    // loaded value is not available yet, so ID must wait one cycle. r0 is
    // hard-wired to zero and can never create a dependency.
    always_comb begin
        hazard = valid_q && ctrl_q[CTRL_MEMREAD] && (rt_q != '0) && id_valid_i &&
                 ((id_uses_rs_i && (id_rs_i == rt_q)) ||
                  (id_uses_rt_i && (id_rt_i == rt_q)));
    end

    // A flushed instruction is discarded anyway, so it must not freeze IF/ID.
    assign stall_o = hazard && !flush_i;
    assign bubble  = flush_i || hazard;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        valid_d    = valid_q;
        aluop_d    = aluop_q;
        regdst_d   = regdst_q;
        memtoreg_d = memtoreg_q;
        ctrl_d     = ctrl_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;

        if (hold_i) begin
            // Frozen: everything keeps its value.
        end else if (bubble) begin
            // Only the control half is cleared; data fields are don't-care
            // while valid is low and simply keep their old contents.
            valid_d    = 1'b0;
            aluop_d    = '0;
            regdst_d   = '0;
            memtoreg_d = '0;
            ctrl_d     = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            valid_d    = id_valid_i;
            // An empty ID slot carries no control so it cannot write state.
            aluop_d    = id_valid_i ? id_aluop_i    : '0;
            regdst_d   = id_valid_i ? id_regdst_i   : '0;
            memtoreg_d = id_valid_i ? id_memtoreg_i : '0;
            ctrl_d     = id_valid_i ? id_ctrl_i     : '0;
            rs_d       = id_rs_i;
            rt_d       = id_rt_i;
            rd_d       = id_rd_i;
            a_d        = id_a_i;
            b_d        = id_b_i;
            imm_d      = id_imm_i;
            pc_d       = id_pc_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            aluop_q    <= '0;
            regdst_q   <= '0;
            memtoreg_q <= '0;
            ctrl_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            aluop_q    <= aluop_d;
            regdst_q   <= regdst_d;
            memtoreg_q <= memtoreg_d;
            ctrl_q     <= ctrl_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid_o    = valid_q;
    assign ex_aluop_o    = aluop_q;
    assign ex_regdst_o   = regdst_q;
    assign ex_memtoreg_o = memtoreg_q;
    assign ex_ctrl_o     = ctrl_q;
    assign ex_rs_o       = rs_q;
    assign ex_rt_o       = rt_q;
    assign ex_rd_o       = rd_q;
    assign ex_a_o        = a_q;
    assign ex_b_o        = b_q;
    assign ex_imm_o      = imm_q;
    assign ex_pc_o       = pc_q;
    assign bubble_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: directed pipeline scenarios followed
//   by randomized traffic, all compared against a cycle-level reference model
//   of what EX should contain after each clock edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    // Control vector encodings {alusrc,regwrite,memread,memwrite,branch,jump,pcsrc}
    localparam logic [6:0] CTRL_RTYPE = 7'b0100000;
    localparam logic [6:0] CTRL_LW    = 7'b1110000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hold_i, flush_i, id_valid_i;
    logic [2:0]    id_aluop_i;
    logic [1:0]    id_regdst_i, id_memtoreg_i;
    logic [6:0]    id_ctrl_i;
    logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic          id_uses_rs_i, id_uses_rt_i;
    logic [DW-1:0] id_a_i, id_b_i, id_imm_i, id_pc_i;
    logic          stall_o, ex_valid_o;
    logic [2:0]    ex_aluop_o;
    logic [1:0]    ex_regdst_o, ex_memtoreg_o;
    logic [6:0]    ex_ctrl_o;
    logic [AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
    logic [DW-1:0] ex_a_o, ex_b_o, ex_imm_o, ex_pc_o;
    logic [CW-1:0] bubble_cnt_o;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_aluop_i(id_aluop_i), .id_regdst_i(id_regdst_i),
        .id_memtoreg_i(id_memtoreg_i), .id_ctrl_i(id_ctrl_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
        .id_a_i(id_a_i), .id_b_i(id_b_i), .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o),
        .ex_regdst_o(ex_regdst_o), .ex_memtoreg_o(ex_memtoreg_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
        .ex_a_o(ex_a_o), .ex_b_o(ex_b_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the instruction the EX stage should currently hold.
    typedef struct {
        bit            valid;
        bit [2:0]      aluop;
        bit [1:0]      regdst;
        bit [1:0]      memtoreg;
        bit [6:0]      ctrl;
        bit [AW-1:0]   rs, rt, rd;
        bit [DW-1:0]   a, b, imm, pc;
    } ex_slot_t;

    ex_slot_t m;
    int       m_cnt;

    task automatic model_reset();
        m     = '{default: '0};
        m_cnt = 0;
    endtask

    // Does the instruction in ID read the register the load in EX writes?
    function automatic bit model_load_use();
        bit is_load = m.valid && m.ctrl[4] && (m.rt != 0);
        bit reads   = (id_uses_rs_i && id_rs_i == m.rt) || (id_uses_rt_i && id_rt_i == m.rt);
        return is_load && id_valid_i && reads;
    endfunction

    task automatic model_edge();
        if (hold_i) return;
        if (flush_i || model_load_use()) begin
            m.valid = 0; m.aluop = 0; m.regdst = 0; m.memtoreg = 0; m.ctrl = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (id_valid_i) begin
            m = '{1'b1, id_aluop_i, id_regdst_i, id_memtoreg_i, id_ctrl_i,
                  id_rs_i, id_rt_i, id_rd_i, id_a_i, id_b_i, id_imm_i, id_pc_i};
        end else begin
            m.valid = 0; m.aluop = 0; m.regdst = 0; m.memtoreg = 0; m.ctrl = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},    64'(ex_valid_o),    64'(m.valid));
        check({tag, ".aluop"},    64'(ex_aluop_o),    64'(m.aluop));
        check({tag, ".regdst"},   64'(ex_regdst_o),   64'(m.regdst));
        check({tag, ".memtoreg"}, 64'(ex_memtoreg_o), 64'(m.memtoreg));
        check({tag, ".ctrl"},     64'(ex_ctrl_o),     64'(m.ctrl));
        check({tag, ".cnt"},      64'(bubble_cnt_o),  64'(m_cnt));
        if (m.valid) begin
            check({tag, ".fields"}, 64'({ex_rs_o, ex_rt_o, ex_rd_o}), 64'({m.rs, m.rt, m.rd}));
            check({tag, ".a"},      64'(ex_a_o),   64'(m.a));
            check({tag, ".b"},      64'(ex_b_o),   64'(m.b));
            check({tag, ".imm"},    64'(ex_imm_o), 64'(m.imm));
            check({tag, ".pc"},     64'(ex_pc_o),  64'(m.pc));
        end
    endtask

    // One cycle: stall checked mid-cycle, EX contents checked just after the edge.
    task automatic step(input string tag);
        @(negedge clk);
        check({tag, ".stall"}, 64'(stall_o), 64'(model_load_use() && !flush_i));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic set_id(input bit valid, input bit [2:0] aluop, input bit [6:0] ctrl,
                          input bit [AW-1:0] rs, input bit [AW-1:0] rt, input bit [AW-1:0] rd,
                          input bit urs, input bit urt);
        id_valid_i    = valid;
        id_aluop_i    = aluop;
        id_regdst_i   = 2'($urandom_range(0, 3));
        id_memtoreg_i = 2'($urandom_range(0, 3));
        id_ctrl_i     = ctrl;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_rd_i       = rd;
        id_uses_rs_i  = urs;
        id_uses_rt_i  = urt;
        id_a_i        = $urandom;
        id_b_i        = $urandom;
        id_imm_i      = $urandom;
        id_pc_i       = $urandom;
    endtask

    initial begin
        reset_n = 1'b0;
        hold_i  = 1'b0;
        flush_i = 1'b0;
        set_id(0, 3'd0, 7'd0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.stall", 64'(stall_o), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // 1: three back-to-back R-type instructions
        for (int i = 0; i < 3; i++) begin
            set_id(1, 3'b010, CTRL_RTYPE, 5'(i + 1), 5'(i + 2), 5'(i + 8), 1, 1);
            step("rtype");
        end

        // 2: lw r5 then add reading r5 -> one stall, one bubble
        set_id(1, 3'b000, CTRL_LW, 5'd1, 5'd5, 5'd0, 1, 0);
        step("lw5");
        set_id(1, 3'b010, CTRL_RTYPE, 5'd5, 5'd2, 5'd9, 1, 1);
        step("lu_bubble");
        check("lu.cnt", 64'(bubble_cnt_o), 64'(1));
        step("lu_add");

        // 3: lw into r0 never causes a hazard
        set_id(1, 3'b000, CTRL_LW, 5'd1, 5'd0, 5'd0, 1, 0);
        step("lw0");
        set_id(1, 3'b010, CTRL_RTYPE, 5'd0, 5'd0, 5'd3, 1, 1);
        step("use_r0");

        // 4: hazard and flush together -> flush wins, one bubble
        set_id(1, 3'b000, CTRL_LW, 5'd1, 5'd7, 5'd0, 1, 0);
        step("lw7");
        set_id(1, 3'b010, CTRL_RTYPE, 5'd2, 5'd7, 5'd4, 1, 1);
        flush_i = 1'b1;
        step("hz_flush");
        flush_i = 1'b0;

        // 5: hold for three cycles during a hazard, then release
        set_id(1, 3'b000, CTRL_LW, 5'd1, 5'd6, 5'd0, 1, 0);
        step("lw6");
        set_id(1, 3'b010, CTRL_RTYPE, 5'd6, 5'd2, 5'd4, 1, 0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) step("hold_hz");
        hold_i = 1'b0;
        step("hold_release");
        step("hold_add");

        // Randomized traffic with a small register pool to provoke hazards
        for (int i = 0; i < 400; i++) begin
            hold_i  = ($urandom_range(0, 9) == 0);
            flush_i = ($urandom_range(0, 6) == 0);
            set_id($urandom_range(0, 4) != 0, 3'($urandom), 7'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
                   1'($urandom), 1'($urandom));
            step("rand");
        end
        hold_i  = 1'b0;

        // 6a: drive the counter to saturation with flushes, then keep flushing
        flush_i = 1'b1;
        while (m_cnt < CNT_MAX) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        check("sat.reach", 64'(bubble_cnt_o), 64'(16'hFFFF));
        for (int i = 0; i < 3; i++) step("sat_hold");
        check("sat.final", 64'(bubble_cnt_o), 64'(16'hFFFF));
        flush_i = 1'b0;

        // 6b: async reset while stalled clears EX and drops stall at once
        set_id(1, 3'b000, CTRL_LW, 5'd1, 5'd3, 5'd0, 1, 0);
        step("lw3");
        set_id(1, 3'b010, CTRL_RTYPE, 5'd3, 5'd1, 5'd2, 1, 0);
        @(negedge clk);
        check("pre_rst.stall", 64'(stall_o), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst.stall", 64'(stall_o), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
